// File: rtl/branch_resolver.sv
// Branch resolver: NZCV flag register, CBZ/CBNZ/B/B.cond evaluation, PC-indexed saturating predictor table.
// Result one cycle after submission, no backpressure; define FLAG_BYPASS_EN to let B.cond see same-cycle flags_in.
module branch_resolver #(
  parameter int PC_WIDTH   = 64,
  parameter int PRED_DEPTH = 16,
  parameter int CTR_WIDTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                fetch_pred_taken,
  input  logic                flags_we,
  input  logic [3:0]          flags_in,
  input  logic                br_valid,
  input  logic [2:0]          br_op,
  input  logic [3:0]          br_cond,
  input  logic                br_reg_zero,
  input  logic [PC_WIDTH-1:0] br_pc,
  input  logic                br_pred_taken,
  input  logic                flush,
  output logic                res_valid,
  output logic                res_taken,
  output logic                res_mispredict,
  output logic [3:0]          flags_out
);

  localparam int IDX_W = $clog2(PRED_DEPTH);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_B     = 3'd1;
  localparam logic [2:0] OP_CBZ   = 3'd2;
  localparam logic [2:0] OP_CBNZ  = 3'd3;
  localparam logic [2:0] OP_BCOND = 3'd4;

  logic [3:0]           r_nzcv;
  logic [CTR_WIDTH-1:0] r_ctr [PRED_DEPTH];
  logic                 r_res_valid;
  logic                 r_res_taken;
  logic                 r_res_mispredict;

  logic [IDX_W-1:0]     w_fetch_idx;
  logic [IDX_W-1:0]     w_br_idx;
  logic [3:0]           w_flags;
  logic                 w_n, w_z, w_c, w_v;
  logic                 w_cond_true;
  logic                 w_taken;
  logic                 w_live;
  logic                 w_upd;
  logic [CTR_WIDTH-1:0] w_ctr_cur;
  logic [CTR_WIDTH-1:0] w_ctr_next;
  logic                 w_unused;

  // Instructions are word-aligned, so PC bits [1:0] never select an entry.
  assign w_fetch_idx = fetch_pc[IDX_W+1:2];
  assign w_br_idx    = br_pc[IDX_W+1:2];
  assign w_unused    = ^{fetch_pc[PC_WIDTH-1:IDX_W+2], fetch_pc[1:0],
                         br_pc[PC_WIDTH-1:IDX_W+2], br_pc[1:0]};

  assign fetch_pred_taken = r_ctr[w_fetch_idx][CTR_WIDTH-1];

`ifdef FLAG_BYPASS_EN
  assign w_flags = flags_we ? flags_in : r_nzcv;
`else
  assign w_flags = r_nzcv;
`endif

  assign {w_n, w_z, w_c, w_v} = w_flags;

  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      4'd0:    w_cond_true = w_z;
      4'd1:    w_cond_true = !w_z;
      4'd2:    w_cond_true = w_c;
      4'd3:    w_cond_true = !w_c;
      4'd4:    w_cond_true = w_n;
      4'd5:    w_cond_true = !w_n;
      4'd6:    w_cond_true = w_v;
      4'd7:    w_cond_true = !w_v;
      4'd8:    w_cond_true = w_c && !w_z;
      4'd9:    w_cond_true = !w_c || w_z;
      4'd10:   w_cond_true = (w_n == w_v);
      4'd11:   w_cond_true = (w_n != w_v);
      4'd12:   w_cond_true = !w_z && (w_n == w_v);
      4'd13:   w_cond_true = w_z || (w_n != w_v);
      4'd14:   w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (br_op)
      OP_NONE:  w_taken = 1'b0;
      OP_B:     w_taken = 1'b1;
      OP_CBZ:   w_taken = br_reg_zero;
      OP_CBNZ:  w_taken = !br_reg_zero;
      OP_BCOND: w_taken = w_cond_true;
      default:  w_taken = 1'b0;
    endcase
  end

  // Only conditional branches train the table; a flushed branch never does.
  assign w_live    = br_valid && !flush;
  assign w_upd     = w_live && (br_op == OP_CBZ || br_op == OP_CBNZ || br_op == OP_BCOND);
  assign w_ctr_cur = r_ctr[w_br_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_ONE;
    end else begin
      if (w_ctr_cur != CTR_MIN) w_ctr_next = w_ctr_cur - CTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nzcv           <= 4'b0000;
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      for (int i = 0; i < PRED_DEPTH; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else begin
      if (flags_we) r_nzcv <= flags_in;
      if (w_upd) r_ctr[w_br_idx] <= w_ctr_next;
      r_res_valid      <= w_live;
      r_res_taken      <= w_live && w_taken;
      r_res_mispredict <= w_live && (w_taken != br_pred_taken);
    end
  end

  assign res_valid      = r_res_valid;
  assign res_taken      = r_res_taken;
  assign res_mispredict = r_res_mispredict;
  assign flags_out      = r_nzcv;

endmodule
